mux_memoria_rr: RTL and testbench

Parametrised successor of the 2:1 registered mux ("mux with memory"). It is generalised to N_CH channels of WIDTH bits, with a valid handshake per channel.
- Selection modes: direct selection or round-robin arbitration.
- Built-in monitor: a saturating counter of 0->1 bit transitions on the registered output, which the comparative benches read directly.
- Sits between the channel sources and the downstream consumer; one word per clock, one cycle of latency.

---
 rtl/mux_memoria_rr_pkg.sv | 32 +++
 rtl/mux_memoria_rr_arbiter.sv | 24 ++
 rtl/mux_memoria_rr.sv | 108 ++++++++++
 tb/tb_mux_memoria_rr.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_memoria_rr_pkg.sv
// Shared constants and helpers for the multi-channel registered mux.
package mux_memoria_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Widest word/counter the helpers handle; callers zero-extend into this.
    localparam int unsigned MAX_W = 64;

    // Number of set bits among the low w bits of v.
    function automatic logic [MAX_W:0] popcount(input logic [MAX_W-1:0] v,
                                                input int unsigned      w);
        logic [MAX_W:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                cnt = cnt + (MAX_W+1)'(v[i]);
            end
        end
        return cnt;
    endfunction

    // a + b clamped to max_val; inputs are far below the helper width, so no wrap.
    function automatic logic [MAX_W:0] sat_add(input logic [MAX_W:0] a,
                                               input logic [MAX_W:0] b,
                                               input logic [MAX_W:0] max_val);
        logic [MAX_W:0] sum;
        sum = a + b;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/mux_memoria_rr_arbiter.sv
// Combinational round-robin grant: first valid channel at or after rr_ptr, wrapping.
module rr_arbiter_param #(
    parameter  int unsigned N_CH  = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  valid_in,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    // Scan from rr_ptr upward; the first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!grant_valid && valid_in[SEL_W'((32'(rr_ptr) + i) % N_CH)]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'((32'(rr_ptr) + i) % N_CH);
            end
        end
    end

endmodule

// File: rtl/mux_memoria_rr.sv
// N-channel registered mux with direct or round-robin selection and a
// saturating counter of 0->1 bit transitions on the registered output.
module mux_memoria_rr
    import mux_memoria_pkg::*;
#(
    parameter  int unsigned WIDTH = 2,
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] data_in,
    input  logic [N_CH-1:0]       valid_in,
    input  logic                  count_clr,
    output logic [WIDTH-1:0]      data_out,
    output logic                  valid_out,
    output logic [SEL_W-1:0]      ch_out,
    output logic [CNT_W-1:0]      rise_count,
    output logic                  sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] words [N_CH];
    logic [SEL_W-1:0] rr_ptr;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             sel_ok;
    logic             load;
    logic [SEL_W-1:0] load_idx;
    logic [WIDTH-1:0] new_word;
    logic [MAX_W:0]   rise_inc;
    logic [CNT_W-1:0] rise_next;
    logic [SEL_W-1:0] ptr_next;

    // Split the flat input bus into per-channel words.
    for (genvar k = 0; k < N_CH; k++) begin : g_words
        assign words[k] = data_in[k*WIDTH +: WIDTH];
    end

    rr_arbiter_param #(
        .N_CH (N_CH)
    ) u_arb (
        .valid_in    (valid_in),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Selector range check, widened by one bit so non-power-of-two N_CH works.
    assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_CH));

    // Pick the channel to load this cycle according to the mode.
    always_comb begin
        load     = 1'b0;
        load_idx = '0;
        if (mode == MODE_DIRECT) begin
            if (sel_ok && valid_in[sel]) begin
                load     = 1'b1;
                load_idx = sel;
            end
        end else begin
            load     = grant_valid;
            load_idx = grant_idx;
        end
    end

    // Only the granted slice reaches the datapath.
    assign new_word  = words[load_idx];
    assign rise_inc  = popcount(MAX_W'(~data_out & new_word), WIDTH);
    assign rise_next = CNT_W'(sat_add((MAX_W+1)'(rise_count), rise_inc,
                                      (MAX_W+1)'(CNT_MAX)));
    assign ptr_next  = (32'(load_idx) == N_CH - 1) ? '0 : SEL_W'(32'(load_idx) + 1);

    // Output register, round-robin pointer and transition counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            ch_out     <= '0;
            rise_count <= '0;
            sat        <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            valid_out <= load;
            if (load) begin
                data_out <= new_word;
                ch_out   <= load_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= ptr_next;
                end
            end
            if (count_clr) begin
                rise_count <= '0;
                sat        <= 1'b0;
            end else if (load) begin
                rise_count <= rise_next;
                if (rise_next == CNT_MAX) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_memoria_rr.sv
// Scoreboard bench: two instances (8-bit and 3-bit counters) share stimulus;
// a behavioural model predicts each cycle and a monitor compares on negedge.
module tb_mux_memoria_rr;

    localparam int unsigned WIDTH = 2;
    localparam int unsigned N_CH  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] data_in;
    logic [3:0] valid_in;
    logic       count_clr;

    logic [1:0] data_out_a, ch_out_a, data_out_b, ch_out_b;
    logic       valid_out_a, sat_a, valid_out_b, sat_b;
    logic [7:0] rise_count_a;
    logic [2:0] rise_count_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_memoria_rr #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .data_in(data_in),
        .valid_in(valid_in), .count_clr(count_clr), .data_out(data_out_a),
        .valid_out(valid_out_a), .ch_out(ch_out_a), .rise_count(rise_count_a),
        .sat(sat_a)
    );

    mux_memoria_rr #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .data_in(data_in),
        .valid_in(valid_in), .count_clr(count_clr), .data_out(data_out_b),
        .valid_out(valid_out_b), .ch_out(ch_out_b), .rise_count(rise_count_b),
        .sat(sat_b)
    );

    typedef struct {
        int data;
        int valid;
        int ch;
        int cnt_a;
        int sat_a;
        int cnt_b;
        int sat_b;
    } exp_t;

    exp_t q[$];

    // Reference model state
    int m_data, m_valid, m_ch, m_ptr, m_cnt_a, m_sat_a, m_cnt_b, m_sat_b;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int word(input int k);
        logic [7:0] t;
        t = data_in >> (k * WIDTH);
        return int'(t[1:0]);
    endfunction

    task automatic model_reset();
        m_data = 0; m_valid = 0; m_ch = 0; m_ptr = 0;
        m_cnt_a = 0; m_sat_a = 0; m_cnt_b = 0; m_sat_b = 0;
    endtask

    // One clock edge of the specified behaviour; pushes the expected outputs.
    task automatic model_clock();
        int g, nw, inc;
        exp_t e;
        if (reset) begin
            model_reset();
        end else begin
            g = -1;
            if (mode == 1'b0) begin
                if (int'(sel) < N_CH && valid_in[sel]) g = int'(sel);
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (g < 0 && valid_in[(m_ptr + i) % N_CH]) g = (m_ptr + i) % N_CH;
                end
            end
            inc = 0;
            if (g >= 0) begin
                nw  = word(g);
                inc = $countones(~m_data & nw & 3);
                if (mode == 1'b1) m_ptr = (g + 1) % N_CH;
                m_data  = nw;
                m_ch    = g;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            if (count_clr) begin
                m_cnt_a = 0; m_sat_a = 0; m_cnt_b = 0; m_sat_b = 0;
            end else if (g >= 0) begin
                m_cnt_a = (m_cnt_a + inc > 255) ? 255 : m_cnt_a + inc;
                m_cnt_b = (m_cnt_b + inc > 7) ? 7 : m_cnt_b + inc;
                if (m_cnt_a == 255) m_sat_a = 1;
                if (m_cnt_b == 7)   m_sat_b = 1;
            end
        end
        e.data = m_data; e.valid = m_valid; e.ch = m_ch;
        e.cnt_a = m_cnt_a; e.sat_a = m_sat_a; e.cnt_b = m_cnt_b; e.sat_b = m_sat_b;
        q.push_back(e);
    endtask

    // Monitor: compare both instances against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("data_a",  int'(data_out_a),   e.data);
            chk("valid_a", int'(valid_out_a),  e.valid);
            chk("ch_a",    int'(ch_out_a),     e.ch);
            chk("cnt_a",   int'(rise_count_a), e.cnt_a);
            chk("sat_a",   int'(sat_a),        e.sat_a);
            chk("data_b",  int'(data_out_b),   e.data);
            chk("valid_b", int'(valid_out_b),  e.valid);
            chk("ch_b",    int'(ch_out_b),     e.ch);
            chk("cnt_b",   int'(rise_count_b), e.cnt_b);
            chk("sat_b",   int'(sat_b),        e.sat_b);
        end
    end

    // Drive inputs on negedge, model the following posedge, return 1ns after it.
    task automatic step(input bit m, input int s, input logic [7:0] d,
                        input logic [3:0] v, input bit c);
        @(negedge clk);
        mode = m; sel = 2'(s); data_in = d; valid_in = v; count_clr = c;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  int'(data_out_a),   0);
        chk({tag, "_valid"}, int'(valid_out_a),  0);
        chk({tag, "_ch"},    int'(ch_out_a),     0);
        chk({tag, "_cnt"},   int'(rise_count_a), 0);
        chk({tag, "_sat"},   int'(sat_a),        0);
        chk({tag, "_cnt_b"}, int'(rise_count_b), 0);
    endtask

    // Assert reset between edges, confirm immediate clear, hold over one edge, release.
    task automatic async_reset_pulse();
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        q.delete();
        model_reset();
        step(1'b1, 0, 8'h00, 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int ch_seq[4];
        int cnt_b_seq[5];
        int sat_b_seq[5];
        ch_seq    = '{0, 1, 3, 0};
        cnt_b_seq = '{2, 4, 6, 7, 7};
        sat_b_seq = '{0, 0, 0, 1, 1};

        reset = 1'b1; mode = 1'b0; sel = 2'd0; data_in = '0; valid_in = '0; count_clr = 1'b0;
        model_reset();
        step(1'b0, 0, 8'h00, 4'b0000, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0000, 1'b0);
        chk_all_zero("reset");
        reset = 1'b0;

        // Direct load of channel 2 = 11
        step(1'b0, 2, 8'h30, 4'b0100, 1'b0);
        chk("basic_data",  int'(data_out_a), 3);
        chk("basic_valid", int'(valid_out_a), 1);
        chk("basic_ch",    int'(ch_out_a), 2);
        chk("basic_cnt",   int'(rise_count_a), 2);

        // Direct selection of an invalid channel holds data
        step(1'b0, 1, 8'h30, 4'b0100, 1'b0);
        chk("hold_valid", int'(valid_out_a), 0);
        chk("hold_data",  int'(data_out_a), 3);
        chk("hold_cnt",   int'(rise_count_a), 2);

        // Round-robin over 1011 from pointer 0
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 0, 8'h00, 4'b1011, 1'b0);
            chk("rr_ch", int'(ch_out_a), ch_seq[i]);
        end

        // Transition counting: 00,01,10,11,00,11 adds 5 to the count of 2
        step(1'b0, 0, 8'h00, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h01, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h02, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h03, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h03, 4'b0001, 1'b0);
        chk("trans_cnt", int'(rise_count_a), 7);

        // Saturation of the 3-bit counter, then clear during a 00->11 load
        step(1'b0, 0, 8'h00, 4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 8'h03, 4'b0001, 1'b0);
            chk("sat_seq_cnt", int'(rise_count_b), cnt_b_seq[i]);
            chk("sat_seq_sat", int'(sat_b), sat_b_seq[i]);
            step(1'b0, 0, 8'h00, 4'b0001, 1'b0);
        end
        step(1'b0, 0, 8'h03, 4'b0001, 1'b1);
        chk("clr_cnt",  int'(rise_count_b), 0);
        chk("clr_sat",  int'(sat_b), 0);
        chk("clr_data", int'(data_out_b), 3);

        // Async reset mid round-robin, then first grant from pointer 0
        step(1'b1, 0, 8'hE4, 4'b1111, 1'b0);
        step(1'b1, 0, 8'hE4, 4'b1111, 1'b0);
        async_reset_pulse();
        step(1'b1, 0, 8'hFF, 4'b1010, 1'b0);
        chk("post_rst_ch", int'(ch_out_a), 1);
        step(1'b1, 0, 8'hFF, 4'b1010, 1'b0);
        chk("post_rst_ch2", int'(ch_out_a), 3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset_pulse();
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 8'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
